// File: rtl/ysyx_22050550_pc_gen_if.sv
// Fetch-request and redirect bundle between the PC generator and its neighbours.
// master = PC generator side, slave = IFU / redirect-source side.
interface ysyx_22050550_pc_gen_if #(
    parameter int XLEN = 64
) ();
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic            if_kill;
    logic            if_pred_taken;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            btb_upd_valid;
    logic [XLEN-1:0] btb_upd_pc;
    logic [XLEN-1:0] btb_upd_target;

    modport master (
        output if_valid, if_pc, if_kill, if_pred_taken,
        input  if_ready, trap_valid, trap_pc, redir_valid, redir_pc,
               btb_upd_valid, btb_upd_pc, btb_upd_target
    );

    modport slave (
        input  if_valid, if_pc, if_kill, if_pred_taken,
        output if_ready, trap_valid, trap_pc, redir_valid, redir_pc,
               btb_upd_valid, btb_upd_pc, btb_upd_target
    );
endinterface

// File: rtl/ysyx_22050550_pc_gen.sv
// Fetch-PC generator: valid/ready fetch request, trap/branch redirect merge, one pending redirect.
// Optional direct-mapped BTB enabled by defining YSYX_22050550_PCGEN_BTB_EN.
//
// state  | meaning
// S_IDLE | out of reset, no request issued yet
// S_RUN  | request outstanding, no redirect pending
// S_PEND | request outstanding, redirect held in pend_pc_q
module ysyx_22050550_pc_gen #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
    parameter int              STEP      = 4,
    parameter int              BTB_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_22050550_pc_gen_if.master        bus
);
    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = XLEN - IW - 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_trap_q, pend_trap_d;
    logic            if_valid_q, if_valid_d;

    logic            hs;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] next_pc;
    logic            btb_hit;
    logic [XLEN-1:0] btb_tgt;

    assign hs = if_valid_q & bus.if_ready;

    // Trap wins the target mux; bit 0 is always cleared on redirect targets.
    always_comb begin
        redir_tgt = bus.trap_valid ? bus.trap_pc : bus.redir_pc;
        redir_tgt[0] = 1'b0;
    end

    always_comb begin
        if (bus.trap_valid)                next_pc = redir_tgt;
        else if (pend_valid_q && pend_trap_q) next_pc = pend_pc_q;
        else if (bus.redir_valid)          next_pc = redir_tgt;
        else if (pend_valid_q)             next_pc = pend_pc_q;
        else if (btb_hit)                  next_pc = btb_tgt;
        else                               next_pc = pc_q + XLEN'(STEP);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        if_valid_d   = if_valid_q;
        case (state_q)
            S_IDLE: begin
                state_d    = S_RUN;
                if_valid_d = 1'b1;
            end
            S_RUN, S_PEND: begin
                if (hs) begin
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                    pend_trap_d  = 1'b0;
                    state_d      = S_RUN;
                end else if (bus.trap_valid ||
                             (bus.redir_valid && !(pend_valid_q && pend_trap_q))) begin
                    // A held trap is never displaced by a later branch redirect.
                    pend_valid_d = 1'b1;
                    pend_trap_d  = bus.trap_valid;
                    pend_pc_d    = redir_tgt;
                    state_d      = S_PEND;
                end
            end
            default: begin
                state_d    = S_IDLE;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            if_valid_q   <= if_valid_d;
        end
    end

`ifdef YSYX_22050550_PCGEN_BTB_EN
    logic            btb_v_q   [BTB_DEPTH];
    logic [TW-1:0]   btb_tag_q [BTB_DEPTH];
    logic [XLEN-1:0] btb_tgt_q [BTB_DEPTH];
    logic [IW-1:0]   lk_idx;
    logic [IW-1:0]   up_idx;
    logic            unused_btb;

    assign lk_idx     = pc_q[IW+1:2];
    assign up_idx     = bus.btb_upd_pc[IW+1:2];
    assign btb_hit    = btb_v_q[lk_idx] && (btb_tag_q[lk_idx] == pc_q[XLEN-1:IW+2]);
    assign btb_tgt    = btb_tgt_q[lk_idx];
    assign unused_btb = ^bus.btb_upd_pc[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) btb_v_q[i] <= 1'b0;
        end else if (bus.btb_upd_valid) begin
            btb_v_q[up_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are qualified by the valid bits.
    always_ff @(posedge clock) begin
        if (bus.btb_upd_valid) begin
            btb_tag_q[up_idx] <= bus.btb_upd_pc[XLEN-1:IW+2];
            btb_tgt_q[up_idx] <= bus.btb_upd_target;
        end
    end
`else
    logic unused_btb;

    assign btb_hit    = 1'b0;
    assign btb_tgt    = '0;
    assign unused_btb = ^{bus.btb_upd_valid, bus.btb_upd_pc, bus.btb_upd_target};
`endif

    assign bus.if_valid      = if_valid_q;
    assign bus.if_pc         = pc_q;
    assign bus.if_kill       = hs & (pend_valid_q | bus.trap_valid | bus.redir_valid);
    assign bus.if_pred_taken = btb_hit;
endmodule

// File: tb/tb_ysyx_22050550_pc_gen.sv
// Randomised + directed bench for ysyx_22050550_pc_gen against a behavioural fetch model.
module tb_ysyx_22050550_pc_gen;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          DEPTH  = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_22050550_pc_gen_if #(.XLEN(64)) bus ();

    ysyx_22050550_pc_gen #(.XLEN(64), .RESET_PC(RST_PC), .STEP(4), .BTB_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model of the fetch stream
    logic        m_valid;
    logic [63:0] m_pc;
    logic        m_pend;
    logic        m_ptrap;
    logic [63:0] m_ppc;
    logic        mb_v   [DEPTH];
    logic [63:0] mb_pc  [DEPTH];
    logic [63:0] mb_tgt [DEPTH];
    logic        obs_kill;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(input logic [63:0] pc);
`ifdef YSYX_22050550_PCGEN_BTB_EN
        int idx = int'((pc >> 2) % DEPTH);
        return mb_v[idx] && ((mb_pc[idx] >> 2) == (pc >> 2));
`else
        return pc === 64'hx;
`endif
    endfunction

    function automatic logic [63:0] m_hit_tgt(input logic [63:0] pc);
        return mb_tgt[int'((pc >> 2) % DEPTH)];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = RST_PC;
        m_pend  = 1'b0;
        m_ptrap = 1'b0;
        m_ppc   = '0;
        for (int i = 0; i < DEPTH; i++) mb_v[i] = 1'b0;
    endtask

    task automatic drive_idle();
        bus.if_ready       = 1'b0;
        bus.trap_valid     = 1'b0;
        bus.trap_pc        = '0;
        bus.redir_valid    = 1'b0;
        bus.redir_pc       = '0;
        bus.btb_upd_valid  = 1'b0;
        bus.btb_upd_pc     = '0;
        bus.btb_upd_target = '0;
    endtask

    // One clock cycle: drive, check combinational view, advance the model across the edge.
    task automatic step(input string tag, input logic rdy,
                        input logic tv, input logic [63:0] tp,
                        input logic rv, input logic [63:0] rp,
                        input logic bu, input logic [63:0] bpc, input logic [63:0] btgt);
        logic        hit, hs;
        logic [63:0] n_pc;
        @(negedge clock);
        bus.if_ready = rdy; bus.trap_valid = tv; bus.trap_pc = tp;
        bus.redir_valid = rv; bus.redir_pc = rp;
        bus.btb_upd_valid = bu; bus.btb_upd_pc = bpc; bus.btb_upd_target = btgt;
        #1;
        hit = m_hit(m_pc);
        hs  = m_valid & rdy;
        check_eq({tag, "_valid"}, 64'(bus.if_valid), 64'(m_valid));
        check_eq({tag, "_pc"}, bus.if_pc, m_pc);
        check_eq({tag, "_kill"}, 64'(bus.if_kill), 64'(hs & (m_pend | tv | rv)));
        check_eq({tag, "_pred"}, 64'(bus.if_pred_taken), 64'(hit));
        obs_kill = bus.if_kill;
        n_pc = m_pc;
        if (hs) begin
            if (tv)                  n_pc = tp & ~64'd1;
            else if (m_pend && m_ptrap) n_pc = m_ppc;
            else if (rv)             n_pc = rp & ~64'd1;
            else if (m_pend)         n_pc = m_ppc;
            else if (hit)            n_pc = m_hit_tgt(m_pc);
            else                     n_pc = m_pc + 64'd4;
        end
        @(posedge clock);
        if (!m_valid) begin
            m_valid = 1'b1;
        end else if (hs) begin
            m_pc   = n_pc;
            m_pend = 1'b0;
        end else if (tv) begin
            m_pend = 1'b1; m_ptrap = 1'b1; m_ppc = tp & ~64'd1;
        end else if (rv && !(m_pend && m_ptrap)) begin
            m_pend = 1'b1; m_ptrap = 1'b0; m_ppc = rp & ~64'd1;
        end
        if (bu) begin
            mb_v  [int'((bpc >> 2) % DEPTH)] = 1'b1;
            mb_pc [int'((bpc >> 2) % DEPTH)] = bpc;
            mb_tgt[int'((bpc >> 2) % DEPTH)] = btgt;
        end
    endtask

    task automatic go(input string tag, input logic rdy);
        step(tag, rdy, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_eq("rst_drop_valid", 64'(bus.if_valid), 64'd0);
        check_eq("rst_drop_pc", bus.if_pc, RST_PC);
        model_reset();
        drive_idle();
        release_reset();
    endtask

    function automatic logic [63:0] rnd_tgt();
        if ($urandom_range(0, 7) == 0) return {$urandom, $urandom};
        return RST_PC + 64'(($urandom_range(0, 63) << 2) | $urandom_range(0, 1));
    endfunction

    initial begin
        drive_idle();
        model_reset();
        obs_kill = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("reset_valid", 64'(bus.if_valid), 64'd0);
        check_eq("reset_pc", bus.if_pc, RST_PC);
        check_eq("reset_kill", 64'(bus.if_kill), 64'd0);
        check_eq("reset_pred", 64'(bus.if_pred_taken), 64'd0);
        repeat (2) @(posedge clock);
        release_reset();

        // sequential fetch
        go("t1", 1'b1);
        #1 check_eq("t1_pc0", bus.if_pc, 64'h8000_0000);
        go("t1", 1'b1);
        #1 check_eq("t1_pc1", bus.if_pc, 64'h8000_0004);
        go("t1", 1'b1);
        #1 check_eq("t1_pc2", bus.if_pc, 64'h8000_0008);
        check_eq("t1_kill", 64'(obs_kill), 64'd0);

        // redirect held across a stall
        step("t2", 1'b0, 1'b0, '0, 1'b1, 64'h8000_0101, 1'b0, '0, '0);
        go("t2", 1'b0);
        go("t2", 1'b0);
        #1 check_eq("t2_hold", bus.if_pc, 64'h8000_0008);
        go("t2", 1'b1);
        check_eq("t2_kill", 64'(obs_kill), 64'd1);
        #1 check_eq("t2_pc", bus.if_pc, 64'h8000_0100);

        // pending trap vs redir ordering
        step("t3a", 1'b0, 1'b1, 64'h8000_0200, 1'b0, '0, 1'b0, '0, '0);
        step("t3a", 1'b0, 1'b0, '0, 1'b1, 64'h8000_0300, 1'b0, '0, '0);
        go("t3a", 1'b1);
        #1 check_eq("t3a_pc", bus.if_pc, 64'h8000_0200);
        step("t3b", 1'b0, 1'b0, '0, 1'b1, 64'h8000_0300, 1'b0, '0, '0);
        step("t3b", 1'b0, 1'b1, 64'h8000_0200, 1'b0, '0, 1'b0, '0, '0);
        go("t3b", 1'b1);
        #1 check_eq("t3b_pc", bus.if_pc, 64'h8000_0200);

        // trap and redir in the handshake cycle
        step("t4", 1'b1, 1'b1, 64'h8000_0500, 1'b1, 64'h8000_0600, 1'b0, '0, '0);
        check_eq("t4_kill", 64'(obs_kill), 64'd1);
        #1 check_eq("t4_pc", bus.if_pc, 64'h8000_0500);

        // wrap at top of address space
        step("t5", 1'b1, 1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0, '0);
        #1 check_eq("t5_top", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        go("t5", 1'b1);
        #1 check_eq("t5_wrap", bus.if_pc, 64'h0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rand", $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, rnd_tgt(),
                 $urandom_range(0, 7) == 0, rnd_tgt(),
                 $urandom_range(0, 3) == 0,
                 RST_PC + 64'($urandom_range(0, 31) << 2), rnd_tgt());
        end

        // reset in the middle of a stalled request
        go("t6", 1'b0);
        mid_reset();
        go("t6", 1'b1);
        #1 check_eq("t6_first_pc", bus.if_pc, RST_PC);

`ifdef YSYX_22050550_PCGEN_BTB_EN
        mid_reset();
        step("btb", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 64'h8000_0010, 64'h8000_0400);
        repeat (4) go("btb", 1'b1);
        #1 check_eq("btb_at", bus.if_pc, 64'h8000_0010);
        check_eq("btb_pred", 64'(bus.if_pred_taken), 64'd1);
        go("btb", 1'b1);
        #1 check_eq("btb_tgt", bus.if_pc, 64'h8000_0400);
        go("btb", 1'b0);
        mid_reset();
        go("btb_clr", 1'b1);
        #1 check_eq("btb_clr_pc", bus.if_pc, 64'h8000_0000);
        repeat (4) go("btb_clr", 1'b1);
        #1 check_eq("btb_clr_at", bus.if_pc, 64'h8000_0010);
        check_eq("btb_clr_pred", 64'(bus.if_pred_taken), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
